axi_rd_slave_model: RTL and testbench

AXI_RD_SLAVE_MODEL -- requirements
Module: axi_rd_slave_model

---
 rtl/axi_rd_slave_model.sv | 164 ++++++++++++++++
 tb/tb_axi_rd_slave_model.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave_model.sv
// AXI read-channel slave model backed by a read-only memory whose word i holds i.
// Optional random rvalid stalls are enabled by defining AXI_RD_RANDOM_STALL_EN.
module axi_rd_slave_model #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int LAT       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] araddr,
    input  logic [7:0]    arlen,
    input  logic [1:0]    arburst,
    input  logic          arvalid,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic [1:0]    rresp,
    output logic          rlast,
    output logic          rvalid,
    input  logic          rready
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
    typedef enum logic [1:0] {K_FIXED, K_INCR, K_WRAP} kind_t;

    state_t          state;
    kind_t           kind;
    kind_t           acc_kind;
    logic            acc_err;
    logic            wrap_ok;
    logic            err;
    logic [CW-1:0]   wait_cnt;
    logic [IW-1:0]   cur_addr;
    logic [IW-1:0]   nxt_addr;
    logic [7:0]      len;
    logic [7:0]      beat;
    logic            stall;

    // The memory is never written, so its content is simply the word index.
    function automatic logic [DW-1:0] mem_word(input logic [IW-1:0] a);
        return DW'(a);
    endfunction

    function automatic logic [IW-1:0] next_addr(input logic [IW-1:0] a, input kind_t k,
                                                 input logic [7:0] l);
        logic [IW-1:0] mask;
        logic [IW-1:0] inc;
        mask = IW'(l[3:0]);
        inc  = a + IW'(1);
        case (k)
            K_FIXED: return a;
            K_WRAP:  return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    if (AW > IW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^araddr[AW-1:IW];
    end

`ifdef AXI_RD_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Illegal WRAP lengths and the reserved type fall back to INCR with SLVERR.
    always_comb begin
        wrap_ok  = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
        acc_kind = K_INCR;
        acc_err  = 1'b0;
        case (arburst)
            2'b00:   acc_kind = K_FIXED;
            2'b10:   begin
                acc_kind = wrap_ok ? K_WRAP : K_INCR;
                acc_err  = !wrap_ok;
            end
            2'b11:   acc_err = 1'b1;
            default: acc_kind = K_INCR;
        endcase
        nxt_addr = next_addr(cur_addr, kind, len);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
            wait_cnt <= '0;
            cur_addr <= '0;
            len      <= '0;
            kind     <= K_FIXED;
            err      <= 1'b0;
            beat     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arvalid && arready) begin
                        cur_addr <= araddr[IW-1:0];
                        len      <= arlen;
                        kind     <= acc_kind;
                        err      <= acc_err;
                        beat     <= '0;
                        wait_cnt <= '0;
                        arready  <= 1'b0;
                        state    <= (LAT == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt == CW'(LAT - 1)) begin
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    // rvalid low here means a beat still has to be presented.
                    if (!rvalid) begin
                        rvalid <= 1'b1;
                        rdata  <= mem_word(cur_addr);
                        rresp  <= err ? 2'b10 : 2'b00;
                        rlast  <= (beat == len);
                    end else if (rready) begin
                        if (rlast) begin
                            state   <= S_IDLE;
                            arready <= 1'b1;
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                        end else begin
                            beat     <= beat + 8'd1;
                            cur_addr <= nxt_addr;
                            if (stall) begin
                                rvalid <= 1'b0;
                            end else begin
                                rdata <= mem_word(nxt_addr);
                                rlast <= (beat + 8'd1 == len);
                            end
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_slave_model.sv
// Self-checking bench for axi_rd_slave_model: directed and random bursts against an
// arithmetic reference of the burst address rules; follows AXI_RD_RANDOM_STALL_EN if defined.
module tb_axi_rd_slave_model;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    axi_rd_slave_model #(.DW(DW), .AW(AW), .MEM_DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

`ifdef AXI_RD_RANDOM_STALL_EN
    // Reference LFSR; m_prev is the value the slave saw at the most recent edge.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_ready(input int mode, input int i, input int held);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return !(i == 1 && held < 3);
        endcase
    endfunction

    // mode: 0 rready always high, 1 random rready, 2 three-cycle hold on beat 2.
    task automatic run_burst(input int addr, input int len, input logic [1:0] burst,
                             input int mode, input int abort_at);
        logic [DW-1:0] exp_d[$];
        logic [1:0]    exp_r;
        logic          exp_v;
        int            n, a, w, base, lat, i, held, cyc;
        bit            wrap_ok;

        n       = len + 1;
        addr    = addr % DEPTH;
        wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        exp_r   = (burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) ? 2'b10 : 2'b00;
        for (int k = 0; k < n; k++) begin
            if (burst == 2'b00) begin
                a = addr;
            end else if (burst == 2'b10 && wrap_ok) begin
                w    = n;
                base = (addr / w) * w;
                a    = base + (addr - base + k) % w;
            end else begin
                a = (addr + k) % DEPTH;
            end
            exp_d.push_back(DW'(a));
        end

        check("arready_idle", arready, 1);
        araddr  = AW'(addr) | (AW'($urandom_range(0, 15)) << 10);
        arlen   = 8'(len);
        arburst = burst;
        arvalid = 1'b1;
        rready  = 1'b0;
        tick();
        arvalid = 1'b0;
        check("arready_busy", arready, 0);

        lat = 0;
        while (!rvalid && lat < 50) begin
            lat++;
            arvalid = 1'($urandom_range(0, 1));
            araddr  = $urandom;
            tick();
        end
        check("first_latency", lat, LAT + 1);

        i = 0; held = 0; cyc = 0; exp_v = 1'b1;
        while (i < n && cyc < 400) begin
            check("rvalid", rvalid, exp_v);
            arvalid = 1'($urandom_range(0, 1));
            araddr  = $urandom;
            arlen   = 8'($urandom);
            if (rvalid) begin
                check("beat", {rdata, rresp, rlast}, {exp_d[i], exp_r, 1'(i == n - 1)});
                if (i == abort_at) begin
                    rst_n  = 1'b0;
                    rready = 1'b0;
                    tick();
                    rst_n   = 1'b1;
                    arvalid = 1'b0;
                    check("abort_rvalid", rvalid, 0);
                    check("abort_arready", arready, 1);
                    check("abort_outputs", {rdata, rresp, rlast}, 0);
                    for (int k = 0; k < 3; k++) begin
                        tick();
                        check("abort_no_more_beats", rvalid, 0);
                    end
                    return;
                end
                rready = pick_ready(mode, i, held);
                tick();
                cyc++;
                if (rready) begin
                    i++;
                    held  = 0;
                    exp_v = 1'b1;
`ifdef AXI_RD_RANDOM_STALL_EN
                    if (i < n) exp_v = !m_prev[0];
`endif
                end else begin
                    held++;
                    exp_v = 1'b1;
                end
            end else begin
                rready = pick_ready(mode, i, held);
                tick();
                cyc++;
                exp_v = 1'b1;
            end
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        check("beats_done", i, n);
        check("idle_rvalid", rvalid, 0);
        check("idle_arready", arready, 1);
    endtask

    initial begin
        rst_n = 1'b0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        tick();
        tick();
        check("rst_arready", arready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_outputs", {rdata, rresp, rlast}, 0);
        rst_n = 1'b1;
        tick();

        run_burst(32'h10, 3, 2'b01, 0, -1);
        run_burst(32'h0E, 3, 2'b10, 0, -1);
        run_burst(32'h3FE, 3, 2'b01, 0, -1);
        run_burst(5, 2, 2'b00, 0, -1);
        run_burst(0, 1, 2'b11, 0, -1);
        run_burst(32'h3FB, 7, 2'b10, 1, -1);
        run_burst(32'h125, 15, 2'b10, 1, -1);
        run_burst(32'h07, 2, 2'b10, 0, -1);
        run_burst(32'h3FF, 0, 2'b01, 0, -1);
        run_burst(32'h20, 3, 2'b01, 2, -1);
        run_burst(32'h80, 7, 2'b01, 0, 1);
        run_burst(32'h40, 0, 2'b01, 0, -1);
        run_burst(0, 15, 2'b01, 0, -1);
        run_burst(32'h3F0, 20, 2'b01, 1, -1);

        for (int r = 0; r < 20; r++) begin
            run_burst(int'($urandom_range(0, 4095)), int'($urandom_range(0, 17)),
                      2'($urandom_range(0, 3)), 1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
